fnd_score_display: RTL and testbench

- Downstream consumer of the game master's `dice_val`, `score_p1` and `score_p2` outputs.
- Drives the Basys3 4-digit 7-segment display, time-multiplexed:
  - digit3 = P1 score
  - digit2 = dash separator
  - digit1 = P2 score
  - digit0 = dice value
- Flags freshly captured dice values by blinking the dice digit for a hold period.
- Blinks the winning player's score digit.

---
 rtl/fnd_score_display.sv | 153 +++++++++++++++
 tb/tb_fnd_score_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fnd_score_display.sv
// fnd_score_display: 4-digit multiplexed P1/dash/P2/dice display, blinking fresh dice and winning scores.
// Latency: every output is registered, so it reflects the scan/blink state one clock later. No backpressure.
// Optional FND_DP_EN: lights the decimal point on the dice digit while the dice value is fresh.
module fnd_score_display #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLINK_CYCLES = 25000000,
    parameter int HOLD_CYCLES  = 100000000,
    parameter int WIN_SCORE    = 2
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [2:0] iDice_Val,
    input  logic [1:0] iScore_P1,
    input  logic [1:0] iScore_P2,
    output logic [3:0] oAn,
    output logic [6:0] oSeg,
    output logic       oDP,
    output logic       oDice_Fresh
);
    localparam int SCAN_W  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(DIGIT_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES);
    localparam logic [2:0]         WIN_L      = 3'(WIN_SCORE);
    localparam logic [6:0]         SEG_DASH   = 7'b0111111;
    localparam logic [6:0]         SEG_BLANK  = 7'b1111111;

    function automatic logic [6:0] seg_code(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [1:0]         digit_idx_q, digit_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q,     phase_d;
    logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic [2:0]         prev_dice_q, prev_dice_d;
    logic [3:0]         an_q,        an_d;
    logic [6:0]         seg_q,       seg_d;
    logic               dp_q,        dp_d;
    logic               fresh_q,     fresh_d;

    logic dice_valid;
    logic fresh_evt;
    logic hold_active;

    always_comb begin
        dice_valid  = (iDice_Val != 3'd0) && (iDice_Val != 3'd7);
        fresh_evt   = dice_valid && (iDice_Val != prev_dice_q);
        hold_active = (hold_cnt_q != '0);

        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end

        // A fresh dice value restarts the blink so the new digit shows first.
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
        if (fresh_evt) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        hold_cnt_d = hold_cnt_q;
        if (fresh_evt) begin
            hold_cnt_d = HOLD_LOAD;
        end else if (hold_active) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end

        prev_dice_d = iDice_Val;
        fresh_d     = hold_active;

        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        case (digit_idx_q)
            2'd0: begin
                an_d = 4'b1110;
                if (dice_valid && !(hold_active && phase_q)) seg_d = seg_code(iDice_Val);
            end
            2'd1: begin
                an_d = 4'b1101;
                if (!(({1'b0, iScore_P2} >= WIN_L) && phase_q)) seg_d = seg_code({1'b0, iScore_P2});
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = SEG_DASH;
            end
            default: begin
                an_d = 4'b0111;
                if (!(({1'b0, iScore_P1} >= WIN_L) && phase_q)) seg_d = seg_code({1'b0, iScore_P1});
            end
        endcase

`ifdef FND_DP_EN
        dp_d = ~((digit_idx_q == 2'd0) && hold_active);
`else
        dp_d = 1'b1;
`endif
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            hold_cnt_q  <= '0;
            prev_dice_q <= 3'd0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            fresh_q     <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hold_cnt_q  <= hold_cnt_d;
            prev_dice_q <= prev_dice_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            fresh_q     <= fresh_d;
        end
    end

    assign oAn         = an_q;
    assign oSeg        = seg_q;
    assign oDP         = dp_q;
    assign oDice_Fresh = fresh_q;

endmodule

// File: tb/tb_fnd_score_display.sv
// Bench for fnd_score_display: directed steps plus random input changes against a time-based reference model.
module tb_fnd_score_display;
    localparam int D = 4;
    localparam int B = 8;
    localparam int H = 32;
    localparam int W = 2;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b1;
    logic [2:0] iDice_Val = 3'd0;
    logic [1:0] iScore_P1 = 2'd0;
    logic [1:0] iScore_P2 = 2'd0;
    logic [3:0] oAn;
    logic [6:0] oSeg;
    logic       oDP;
    logic       oDice_Fresh;

    fnd_score_display #(
        .DIGIT_CYCLES(D),
        .BLINK_CYCLES(B),
        .HOLD_CYCLES (H),
        .WIN_SCORE   (W)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iDice_Val  (iDice_Val),
        .iScore_P1  (iScore_P1),
        .iScore_P2  (iScore_P2),
        .oAn        (oAn),
        .oSeg       (oSeg),
        .oDP        (oDP),
        .oDice_Fresh(oDice_Fresh)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;

    // Reference model state: edges since reset release, last fresh-dice edge, previous dice.
    int   k = 0;
    int   evt_edge = 0;
    bit   have_evt = 0;
    int   prev_dice = 0;
    logic [6:0] seg_tbl [7] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010};

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"},    {3'b0, oAn},         7'b0001111);
        chk({tag, "_seg"},   oSeg,                7'b1111111);
        chk({tag, "_dp"},    {6'b0, oDP},         7'b0000001);
        chk({tag, "_fresh"}, {6'b0, oDice_Fresh}, 7'b0000000);
    endtask

    // One clock: outputs after edge k reflect state after edge k-1 and the inputs sampled at edge k.
    task automatic step();
        int m, slot, age, ph, dice, p1, p2;
        bit hold_on;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        @(posedge iClk);
        k++;
        m = k - 1;
        dice = int'(iDice_Val);
        p1 = int'(iScore_P1);
        p2 = int'(iScore_P2);
        slot = (m / D) % 4;
        age = m - evt_edge;
        ph = (age / B) % 2;
        hold_on = have_evt && (age < H);
        e_an = ~(4'b0001 << slot);
        case (slot)
            0: e_seg = (dice >= 1 && dice <= 6 && !(hold_on && ph == 1)) ? seg_tbl[dice] : 7'b1111111;
            1: e_seg = (p2 >= W && ph == 1) ? 7'b1111111 : seg_tbl[p2];
            2: e_seg = 7'b0111111;
            default: e_seg = (p1 >= W && ph == 1) ? 7'b1111111 : seg_tbl[p1];
        endcase
`ifdef FND_DP_EN
        e_dp = !(slot == 0 && hold_on);
`else
        e_dp = 1'b1;
`endif
        if (dice >= 1 && dice <= 6 && dice != prev_dice) begin
            have_evt = 1;
            evt_edge = k;
        end
        prev_dice = dice;
        #1;
        chk("an",    {3'b0, oAn},         {3'b0, e_an});
        chk("seg",   oSeg,                e_seg);
        chk("dp",    {6'b0, oDP},         {6'b0, e_dp});
        chk("fresh", {6'b0, oDice_Fresh}, {6'b0, hold_on});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_reset();
        @(negedge iClk);
        iRst_n = 1'b1;
        k = 0;
        evt_edge = 0;
        have_evt = 0;
        prev_dice = 0;
    endtask

    initial begin
        #2 iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        #1 chk_reset_outputs("reset");
        release_reset();

        // Idle scan with blank dice and zero scores.
        run(40);

        // Static content (dice 3 also starts a hold because previous dice was 0).
        iDice_Val = 3'd3; iScore_P1 = 2'd1; iScore_P2 = 2'd0;
        run(64);

        // Dice 0 -> 5, restart with 2 at hold clock 20, then invalid 7.
        iDice_Val = 3'd0;
        run(6);
        iDice_Val = 3'd5;
        run(20);
        iDice_Val = 3'd2;
        run(40);
        iDice_Val = 3'd7;
        run(16);
        iDice_Val = 3'd2;
        run(8);

        // Both players at the win score, then P1 drops back.
        iScore_P1 = 2'd2; iScore_P2 = 2'd2;
        run(48);
        iScore_P1 = 2'd0;
        run(24);
        iScore_P2 = 2'd3;
        run(24);

        // Asynchronous reset in the middle of a scan slot.
        #3 iRst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        repeat (2) @(posedge iClk);
        #1 chk_reset_outputs("reset_held");
        iDice_Val = 3'd1; iScore_P1 = 2'd0; iScore_P2 = 2'd0;
        release_reset();
        run(20);
        iDice_Val = 3'd4;
        run(40);

        // Random input traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) iDice_Val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) iScore_P1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) iScore_P2 = 2'($urandom_range(0, 3));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
